// File: rtl/shared_counter_pkg.sv
// Shared types and defaults for the shared counter pool: command opcodes,
// sequencer states and default pool geometry.
package shared_counter_pkg;

   localparam int DEF_N_SUB = 16;
   localparam int DEF_G     = 4;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_INC   = 3'd1,
      OP_ALLOC = 3'd2,
      OP_FREE  = 3'd3,
      OP_LOAD  = 3'd4,
      OP_READ  = 3'd5,
      OP_CLEAR = 3'd6,
      OP_RSVD  = 3'd7
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_LOAD
   } state_t;

endpackage

// File: rtl/shared_counter_if.sv
// Command, load-stream, response and read-stream signals of the shared counter pool.
interface shared_counter_if
   import shared_counter_pkg::*;
#(
   parameter int N_SUB = DEF_N_SUB,
   parameter int G     = DEF_G,
   parameter int ID_W  = $clog2(N_SUB),
   parameter int SZ_W  = $clog2(N_SUB + 1)
);
   logic            cmd_valid;
   logic            cmd_ready;
   cmd_op_t         cmd_op;
   logic [ID_W-1:0] cmd_id;
   logic [SZ_W-1:0] cmd_size;
   logic [G-1:0]    ld_data;
   logic            ld_valid;
   logic            rsp_valid;
   logic            rsp_ok;
   logic [ID_W-1:0] rsp_id;
   logic [G-1:0]    rd_data;
   logic            rd_valid;
   logic            rd_last;
   logic            ovf;
   logic [SZ_W-1:0] free_count;

   modport master (
      output cmd_valid, cmd_op, cmd_id, cmd_size, ld_data, ld_valid,
      input  cmd_ready, rsp_valid, rsp_ok, rsp_id, rd_data, rd_valid, rd_last, ovf, free_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_id, cmd_size, ld_data, ld_valid,
      output cmd_ready, rsp_valid, rsp_ok, rsp_id, rd_data, rd_valid, rd_last, ovf, free_count
   );
endinterface

// File: rtl/shared_counter_first_fit.sv
// First-fit search: lowest base index with `size` contiguous unused subcounters.
module shared_counter_first_fit
   import shared_counter_pkg::*;
#(
   parameter int N_SUB = DEF_N_SUB,
   parameter int ID_W  = $clog2(N_SUB),
   parameter int SZ_W  = $clog2(N_SUB + 1)
) (
   input  logic [N_SUB-1:0] used,
   input  logic [SZ_W-1:0]  size,
   output logic             found,
   output logic [ID_W-1:0]  base
);
   logic fits;

   // Scan from the top down so the lowest fitting base is the last one written.
   always_comb begin
      found = 1'b0;
      base  = '0;
      fits  = 1'b0;
      for (int b = N_SUB - 1; b >= 0; b--) begin
         fits = (size != '0) && (int'(size) <= N_SUB - b);
         for (int k = 0; k < N_SUB; k++) begin
            if (k >= b && k < b + int'(size) && used[k]) fits = 1'b0;
         end
         if (fits) begin
            found = 1'b1;
            base  = ID_W'(b);
         end
      end
   end
endmodule

// File: rtl/shared_counter_pool.sv
// Pool of N_SUB G-bit subcounters grouped into variable-length counters,
// driven by a valid/ready command port with streamed read-out and load.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | accepting commands; single-cycle ops complete here
//   READ    | streaming remaining counter words out, one per cycle
//   LOAD    | writing counter words from ld_data on each ld_valid
module shared_counter_pool
   import shared_counter_pkg::*;
#(
   parameter int  N_SUB = DEF_N_SUB,
   parameter int  G     = DEF_G,
   localparam int ID_W  = $clog2(N_SUB),
   localparam int SZ_W  = $clog2(N_SUB + 1)
) (
   input logic             clk,
   input logic             rst,
   shared_counter_if.slave bus
);
   state_t           state_q;
   logic [N_SUB-1:0] used_q;
   logic [N_SUB-1:0] head_q;
   logic [G-1:0]     data_q [N_SUB];
   logic [ID_W-1:0]  ptr_q;
   logic [SZ_W-1:0]  left_q;
   logic [SZ_W-1:0]  free_q;

   logic             rsp_valid_q, rsp_ok_q, rd_valid_q, rd_last_q, ovf_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic [G-1:0]     rd_data_q;

   logic [N_SUB-1:0] seg_mask;
   logic [SZ_W-1:0]  seg_len;
   logic             run;
   logic             tgt_ok;
   logic [G-1:0]     inc_data [N_SUB];
   logic             carry;
   logic             ff_found;
   logic [ID_W-1:0]  ff_base;

   shared_counter_first_fit #(.N_SUB(N_SUB), .ID_W(ID_W), .SZ_W(SZ_W)) u_first_fit (
      .used  (used_q),
      .size  (bus.cmd_size),
      .found (ff_found),
      .base  (ff_base)
   );

   // Segment of cmd_id: the head plus the unbroken run of used non-head words above it.
   always_comb begin
      seg_mask = '0;
      seg_len  = '0;
      run      = 1'b0;
      for (int i = 0; i < N_SUB; i++) begin
         if (ID_W'(i) == bus.cmd_id)     run = head_q[i];
         else if (ID_W'(i) > bus.cmd_id) run = run && used_q[i] && !head_q[i];
         else                            run = 1'b0;
         seg_mask[i] = run;
         if (run) seg_len = seg_len + SZ_W'(1);
      end
   end

   assign tgt_ok = head_q[bus.cmd_id];

   // Ripple carry from the head word upward; a carry out of the top word is overflow.
   always_comb begin
      carry = 1'b1;
      for (int i = 0; i < N_SUB; i++) begin
         inc_data[i] = data_q[i];
         if (seg_mask[i]) {carry, inc_data[i]} = {1'b0, data_q[i]} + (G + 1)'(carry);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         used_q      <= '0;
         head_q      <= '0;
         for (int i = 0; i < N_SUB; i++) data_q[i] <= '0;
         ptr_q       <= '0;
         left_q      <= '0;
         free_q      <= SZ_W'(N_SUB);
         rsp_valid_q <= 1'b0;
         rsp_ok_q    <= 1'b0;
         rsp_id_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_ok_q    <= 1'b0;
         rsp_id_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
         ovf_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid && bus.cmd_op != OP_NOP) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= bus.cmd_id;
                  case (bus.cmd_op)
                     OP_INC: if (tgt_ok) begin
                        data_q   <= inc_data;
                        ovf_q    <= carry;
                        rsp_ok_q <= 1'b1;
                     end
                     OP_ALLOC: begin
                        rsp_id_q <= '0;
                        if (ff_found) begin
                           for (int i = 0; i < N_SUB; i++) begin
                              if (i >= int'(ff_base) && i < int'(ff_base) + int'(bus.cmd_size)) begin
                                 used_q[i] <= 1'b1;
                                 data_q[i] <= '0;
                              end
                           end
                           head_q[ff_base] <= 1'b1;
                           free_q          <= free_q - bus.cmd_size;
                           rsp_ok_q        <= 1'b1;
                           rsp_id_q        <= ff_base;
                        end
                     end
                     OP_FREE: if (tgt_ok) begin
                        for (int i = 0; i < N_SUB; i++) begin
                           if (seg_mask[i]) begin
                              used_q[i] <= 1'b0;
                              head_q[i] <= 1'b0;
                           end
                        end
                        free_q   <= free_q + seg_len;
                        rsp_ok_q <= 1'b1;
                     end
                     OP_CLEAR: if (tgt_ok) begin
                        for (int i = 0; i < N_SUB; i++) if (seg_mask[i]) data_q[i] <= '0;
                        rsp_ok_q <= 1'b1;
                     end
                     OP_LOAD: if (tgt_ok) begin
                        state_q  <= ST_LOAD;
                        ptr_q    <= bus.cmd_id;
                        left_q   <= seg_len;
                        rsp_ok_q <= 1'b1;
                     end
                     OP_READ: if (tgt_ok) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= data_q[bus.cmd_id];
                        rd_last_q  <= (seg_len == SZ_W'(1));
                        ptr_q      <= bus.cmd_id + ID_W'(1);
                        left_q     <= seg_len - SZ_W'(1);
                        rsp_ok_q   <= 1'b1;
                        if (seg_len != SZ_W'(1)) state_q <= ST_READ;
                     end
                     default: ;
                  endcase
               end
            end
            ST_READ: begin
               rd_valid_q <= 1'b1;
               rd_data_q  <= data_q[ptr_q];
               rd_last_q  <= (left_q == SZ_W'(1));
               ptr_q      <= ptr_q + ID_W'(1);
               left_q     <= left_q - SZ_W'(1);
               if (left_q == SZ_W'(1)) state_q <= ST_IDLE;
            end
            ST_LOAD: begin
               if (bus.ld_valid) begin
                  data_q[ptr_q] <= bus.ld_data;
                  ptr_q         <= ptr_q + ID_W'(1);
                  left_q        <= left_q - SZ_W'(1);
                  if (left_q == SZ_W'(1)) state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = (state_q == ST_IDLE) && rst;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_ok     = rsp_ok_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_last    = rd_last_q;
   assign bus.ovf        = ovf_q;
   assign bus.free_count = free_q;
endmodule

// File: tb/tb_shared_counter_pool.sv
// Directed bench for shared_counter_pool with N_SUB=8, G=4.
module tb_shared_counter_pool;
   import shared_counter_pkg::*;

   logic clk;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   shared_counter_if #(.N_SUB(8), .G(4)) bus ();

   shared_counter_pool #(.N_SUB(8), .G(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic do_cmd(input cmd_op_t op, input logic [2:0] id, input logic [3:0] size);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_id    = id;
      bus.cmd_size  = size;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
   endtask

   task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      bus.ld_valid = 1'b1;
      bus.ld_data  = a; @(posedge clk); #1;
      bus.ld_data  = b; @(posedge clk); #1;
      bus.ld_data  = c; @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (bus.free_count !== 4'd8) $display("FAIL rst_free got %0d exp 8", bus.free_count); else n_pass++;
      n_total++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.cmd_ready); else n_pass++;
      n_total++; if ({bus.rsp_valid, bus.rd_valid, bus.ovf} !== 3'b000) $display("FAIL rst_outs got %b exp 000", {bus.rsp_valid, bus.rd_valid, bus.ovf}); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", bus.cmd_ready); else n_pass++;
   endtask

   task automatic test_alloc();
      do_cmd(OP_ALLOC, 3'd0, 4'd3);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok} !== 2'b11) $display("FAIL alloc3_ok got %b exp 11", {bus.rsp_valid, bus.rsp_ok}); else n_pass++;
      n_total++; if (bus.rsp_id !== 3'd0) $display("FAIL alloc3_id got %0d exp 0", bus.rsp_id); else n_pass++;
      n_total++; if (bus.free_count !== 4'd5) $display("FAIL alloc3_free got %0d exp 5", bus.free_count); else n_pass++;
      do_cmd(OP_ALLOC, 3'd0, 4'd2);
      n_total++; if ({bus.rsp_ok, bus.rsp_id} !== {1'b1, 3'd3}) $display("FAIL alloc2_id got ok=%b id=%0d exp ok=1 id=3", bus.rsp_ok, bus.rsp_id); else n_pass++;
      n_total++; if (bus.free_count !== 4'd3) $display("FAIL alloc2_free got %0d exp 3", bus.free_count); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rsp_pulse got %b exp 0", bus.rsp_valid); else n_pass++;
   endtask

   task automatic test_load_inc_read();
      do_cmd(OP_LOAD, 3'd0, 4'd0);
      n_total++; if ({bus.rsp_ok, bus.cmd_ready} !== 2'b10) $display("FAIL load_start got ok/ready=%b exp 10", {bus.rsp_ok, bus.cmd_ready}); else n_pass++;
      load3(4'hF, 4'hF, 4'h2);
      n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL load_done_ready got %b exp 1", bus.cmd_ready); else n_pass++;
      do_cmd(OP_INC, 3'd0, 4'd0);
      n_total++; if ({bus.rsp_ok, bus.ovf} !== 2'b10) $display("FAIL inc_ok_ovf got %b exp 10", {bus.rsp_ok, bus.ovf}); else n_pass++;
      do_cmd(OP_READ, 3'd0, 4'd0);
      n_total++; if ({bus.rsp_valid, bus.rd_valid, bus.rd_data, bus.rd_last} !== {2'b11, 4'h0, 1'b0}) $display("FAIL rd_w0 got v=%b rv=%b d=%h l=%b exp 1 1 0 0", bus.rsp_valid, bus.rd_valid, bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_valid, bus.rd_data, bus.rd_last} !== {1'b1, 4'h0, 1'b0}) $display("FAIL rd_w1 got rv=%b d=%h l=%b exp 1 0 0", bus.rd_valid, bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_valid, bus.rd_data, bus.rd_last} !== {1'b1, 4'h3, 1'b1}) $display("FAIL rd_w2 got rv=%b d=%h l=%b exp 1 3 1", bus.rd_valid, bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_valid, bus.rd_last, bus.cmd_ready} !== 3'b001) $display("FAIL rd_end got rv/l/ready=%b exp 001", {bus.rd_valid, bus.rd_last, bus.cmd_ready}); else n_pass++;
   endtask

   task automatic test_overflow();
      do_cmd(OP_LOAD, 3'd0, 4'd0);
      load3(4'hF, 4'hF, 4'hF);
      do_cmd(OP_INC, 3'd0, 4'd0);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok, bus.ovf} !== 3'b111) $display("FAIL ovf_pulse got %b exp 111", {bus.rsp_valid, bus.rsp_ok, bus.ovf}); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.ovf !== 1'b0) $display("FAIL ovf_clear got %b exp 0", bus.ovf); else n_pass++;
      do_cmd(OP_READ, 3'd0, 4'd0);
      n_total++; if (bus.rd_data !== 4'h0) $display("FAIL ovf_rd0 got %h exp 0", bus.rd_data); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.rd_data !== 4'h0) $display("FAIL ovf_rd1 got %h exp 0", bus.rd_data); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_data, bus.rd_last} !== {4'h0, 1'b1}) $display("FAIL ovf_rd2 got d=%h l=%b exp 0 1", bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      do_cmd(OP_LOAD, 3'd3, 4'd0);
      bus.ld_valid = 1'b1;
      bus.ld_data  = 4'h5; @(posedge clk); #1;
      bus.ld_data  = 4'h6; @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      do_cmd(OP_INC, 3'd3, 4'd0);
      do_cmd(OP_INC, 3'd3, 4'd0);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok, bus.ovf} !== 3'b110) $display("FAIL b2b_inc got %b exp 110", {bus.rsp_valid, bus.rsp_ok, bus.ovf}); else n_pass++;
      do_cmd(OP_READ, 3'd3, 4'd0);
      n_total++; if ({bus.rd_data, bus.rd_last} !== {4'h7, 1'b0}) $display("FAIL b2b_rd0 got d=%h l=%b exp 7 0", bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_data, bus.rd_last} !== {4'h6, 1'b1}) $display("FAIL b2b_rd1 got d=%h l=%b exp 6 1", bus.rd_data, bus.rd_last); else n_pass++;
      do_cmd(OP_CLEAR, 3'd3, 4'd0);
      n_total++; if (bus.rsp_ok !== 1'b1) $display("FAIL clear_ok got %b exp 1", bus.rsp_ok); else n_pass++;
      do_cmd(OP_READ, 3'd3, 4'd0);
      n_total++; if (bus.rd_data !== 4'h0) $display("FAIL clear_rd0 got %h exp 0", bus.rd_data); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_data, bus.rd_last} !== {4'h0, 1'b1}) $display("FAIL clear_rd1 got d=%h l=%b exp 0 1", bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_free_realloc();
      do_cmd(OP_FREE, 3'd0, 4'd0);
      n_total++; if (bus.rsp_ok !== 1'b1) $display("FAIL free0_ok got %b exp 1", bus.rsp_ok); else n_pass++;
      n_total++; if (bus.free_count !== 4'd6) $display("FAIL free0_count got %0d exp 6", bus.free_count); else n_pass++;
      do_cmd(OP_ALLOC, 3'd0, 4'd4);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok, bus.rsp_id} !== {2'b10, 3'd0}) $display("FAIL alloc4_nofit got v=%b ok=%b id=%0d exp 1 0 0", bus.rsp_valid, bus.rsp_ok, bus.rsp_id); else n_pass++;
      n_total++; if (bus.free_count !== 4'd6) $display("FAIL alloc4_count got %0d exp 6", bus.free_count); else n_pass++;
      do_cmd(OP_ALLOC, 3'd0, 4'd0);
      n_total++; if (bus.rsp_ok !== 1'b0) $display("FAIL alloc0_ok got %b exp 0", bus.rsp_ok); else n_pass++;
      do_cmd(OP_ALLOC, 3'd0, 4'd3);
      n_total++; if ({bus.rsp_ok, bus.rsp_id} !== {1'b1, 3'd0}) $display("FAIL realloc3 got ok=%b id=%0d exp 1 0", bus.rsp_ok, bus.rsp_id); else n_pass++;
      n_total++; if (bus.free_count !== 4'd3) $display("FAIL realloc3_count got %0d exp 3", bus.free_count); else n_pass++;
      do_cmd(OP_FREE, 3'd1, 4'd0);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok, bus.rsp_id} !== {2'b10, 3'd1}) $display("FAIL free_nonhead got v=%b ok=%b id=%0d exp 1 0 1", bus.rsp_valid, bus.rsp_ok, bus.rsp_id); else n_pass++;
      do_cmd(OP_RSVD, 3'd0, 4'd0);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok} !== 2'b10) $display("FAIL rsvd got %b exp 10", {bus.rsp_valid, bus.rsp_ok}); else n_pass++;
   endtask

   task automatic test_load_gapped();
      logic       pat [5];
      logic [3:0] dat [5];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      dat = '{4'hA, 4'h1, 4'h2, 4'hB, 4'hC};
      do_cmd(OP_LOAD, 3'd0, 4'd0);
      n_total++; if (bus.rsp_ok !== 1'b1) $display("FAIL gap_load_ok got %b exp 1", bus.rsp_ok); else n_pass++;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_READ;
      bus.cmd_id    = 3'd0;
      for (int k = 0; k < 5; k++) begin
         bus.ld_valid = pat[k];
         bus.ld_data  = dat[k];
         n_total++; if (bus.cmd_ready !== 1'b0) $display("FAIL gap_ready_%0d got %b exp 0", k, bus.cmd_ready); else n_pass++;
         @(posedge clk); #1;
         if (k < 4) begin
            n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL gap_noaccept_%0d got %b exp 0", k, bus.rsp_valid); else n_pass++;
         end
      end
      bus.ld_valid = 1'b0;
      n_total++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) $display("FAIL gap_idle got ready/rsp=%b exp 10", {bus.cmd_ready, bus.rsp_valid}); else n_pass++;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      n_total++; if ({bus.rsp_valid, bus.rd_data, bus.rd_last} !== {1'b1, 4'hA, 1'b0}) $display("FAIL gap_rd0 got v=%b d=%h l=%b exp 1 a 0", bus.rsp_valid, bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_data, bus.rd_last} !== {4'hB, 1'b0}) $display("FAIL gap_rd1 got d=%h l=%b exp b 0", bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_data, bus.rd_last} !== {4'hC, 1'b1}) $display("FAIL gap_rd2 got d=%h l=%b exp c 1", bus.rd_data, bus.rd_last); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_read();
      do_cmd(OP_READ, 3'd0, 4'd0);
      n_total++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 4'hA}) $display("FAIL mid_rd0 got v=%b d=%h exp 1 a", bus.rd_valid, bus.rd_data); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_valid, bus.rd_last} !== 2'b00) $display("FAIL mid_abort got %b exp 00", {bus.rd_valid, bus.rd_last}); else n_pass++;
      n_total++; if (bus.free_count !== 4'd8) $display("FAIL mid_free got %0d exp 8", bus.free_count); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL mid_ready got %b exp 1", bus.cmd_ready); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({bus.rd_valid, bus.cmd_ready} !== 2'b01) $display("FAIL mid_after got rv/ready=%b exp 01", {bus.rd_valid, bus.cmd_ready}); else n_pass++;
      do_cmd(OP_INC, 3'd0, 4'd0);
      n_total++; if ({bus.rsp_valid, bus.rsp_ok} !== 2'b10) $display("FAIL mid_nohead got %b exp 10", {bus.rsp_valid, bus.rsp_ok}); else n_pass++;
   endtask

   initial begin
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_id    = '0;
      bus.cmd_size  = '0;
      bus.ld_data   = '0;
      bus.ld_valid  = 1'b0;
      test_reset();
      test_alloc();
      test_load_inc_read();
      test_overflow();
      test_back_to_back();
      test_free_realloc();
      test_load_gapped();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
